// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the BCD <-> binary conversion blocks.
package bcd_pkg;

   localparam int unsigned BCD_NIBBLE_W  = 4;
   localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } bcd_conv_state_t;

endpackage : bcd_pkg

// File: rtl/bcd_rdd_step.sv
// One reverse-double-dabble iteration: shift {bcd,acc} right by one, then
// correct every BCD nibble that reached 8 or more by subtracting 3.
module bcd_rdd_step
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 8
) (
   input  logic [DIGITS*BCD_NIBBLE_W-1:0] bcd_i,
   input  logic [DIGITS*BCD_NIBBLE_W-1:0] acc_i,
   output logic [DIGITS*BCD_NIBBLE_W-1:0] bcd_c,
   output logic [DIGITS*BCD_NIBBLE_W-1:0] acc_c
);

   localparam int unsigned W = DIGITS * BCD_NIBBLE_W;

   logic [W-1:0]            bcd_sh;
   logic [BCD_NIBBLE_W-1:0] nib;

   // Shift the pair as one word, then apply per-nibble correction to the BCD half.
   always_comb begin
      acc_c  = {bcd_i[0], acc_i[W-1:1]};
      bcd_sh = {1'b0, bcd_i[W-1:1]};
      bcd_c  = '0;
      nib    = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         nib = bcd_sh[i*BCD_NIBBLE_W +: BCD_NIBBLE_W];
         bcd_c[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
      end
   end

endmodule : bcd_rdd_step

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one reverse-double-dabble iteration per
// clock, valid/ready on both sides, one conversion in flight.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 8,
   parameter int unsigned BIN_W  = 24
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DIGITS*BCD_NIBBLE_W-1:0] in_bcd,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [BIN_W-1:0]               out_bin,
   output logic                           out_err,
   output logic                           out_ovf
);

   localparam int unsigned     BCD_W    = DIGITS * BCD_NIBBLE_W;
   localparam int unsigned     CNT_W    = $clog2(BCD_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCD_W - 1);

   bcd_conv_state_t state_q, state_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [BCD_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [BIN_W-1:0] out_bin_q, out_bin_d;
   logic             out_err_q, out_err_d;
   logic             out_ovf_q, out_ovf_d;

   logic [BCD_W-1:0] bcd_step_c;
   logic [BCD_W-1:0] acc_step_c;
   logic             err_in_c;
   logic             ovf_c;

   bcd_rdd_step #(
      .DIGITS (DIGITS)
   ) u_step (
      .bcd_i (bcd_q),
      .acc_i (acc_q),
      .bcd_c (bcd_step_c),
      .acc_c (acc_step_c)
   );

   // Flag any incoming nibble that is not a decimal digit.
   always_comb begin
      err_in_c = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (in_bcd[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] > BCD_DIGIT_MAX) begin
            err_in_c = 1'b1;
         end
      end
   end

   // Overflow means the decimal value needed bits above the output width.
   if (BIN_W < BCD_W) begin : g_ovf
      assign ovf_c = |acc_step_c[BCD_W-1:BIN_W];
   end else begin : g_no_ovf
      assign ovf_c = 1'b0;
   end

   // Next-state, datapath and output-register update.
   always_comb begin
      state_d     = state_q;
      bcd_d       = bcd_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_bin_d   = out_bin_q;
      out_err_d   = out_err_q;
      out_ovf_d   = out_ovf_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               state_d    = CONV;
               bcd_d      = in_bcd;
               acc_d      = '0;
               cnt_d      = '0;
               err_d      = err_in_c;
               in_ready_d = 1'b0;
            end
         end
         CONV: begin
            bcd_d = bcd_step_c;
            acc_d = acc_step_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_err_d   = err_q;
               out_ovf_d   = ovf_c && !err_q;
               out_bin_d   = err_q ? '0 : acc_step_c[BIN_W-1:0];
            end
         end
         DONE: begin
            if (out_valid_q && out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and register bank; reset aborts any conversion in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bcd_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_bin_q   <= '0;
         out_err_q   <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcd_q       <= bcd_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_bin_q   <= out_bin_d;
         out_err_q   <= out_err_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_bin   = out_bin_q;
   assign out_err   = out_err_q;
   assign out_ovf   = out_ovf_q;

endmodule : bcd_to_bin_seq

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: the driver pushes expected results on
// each accepted input, the monitor pops and compares on each output handshake.
module tb_bcd_to_bin_seq;

   localparam int LAT = 32;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_bcd;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_bin;
   logic        out_err;
   logic        out_ovf;

   bcd_to_bin_seq #(.DIGITS(8), .BIN_W(24)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_err   (out_err),
      .out_ovf   (out_ovf)
   );

   typedef struct {
      logic [23:0] bin;
      logic        err;
      logic        ovf;
      int          acc_cyc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   rand_rdy  = 0;
   bit   rdy_force = 1;
   bit   ov_prev   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // out_ready driver: changes just after each rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
      end
   end

   // Monitor: checks latency on out_valid rise and results on handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !ov_prev) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
               chk("latency", 32'(cyc - q[0].acc_cyc), 32'(LAT));
            end
         end
         if (out_valid && out_ready && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_bin", 32'(out_bin), 32'(e.bin));
            chk("out_err", 32'(out_err), 32'(e.err));
            chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
         end
      end
      ov_prev = out_valid;
   end

   // Present one word; returns just after the accepting edge.
   task automatic send(input logic [31:0] w, input logic [23:0] eb,
                       input logic ee, input logic eo, input bit push);
      bit done = 0;
      int n    = 0;
      in_bcd   = w;
      in_valid = 1'b1;
      while (!done && n < 1000) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
            if (push) q.push_back('{bin: eb, err: ee, ovf: eo, acc_cyc: cyc + 1});
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 32'(done), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
   endtask

   logic [31:0] dw [6] = '{32'h12345678, 32'h00000000, 32'h16777215,
                           32'h16777216, 32'h99999999, 32'h000000A0};
   logic [23:0] db [6] = '{24'hBC614E, 24'h000000, 24'hFFFFFF,
                           24'h000000, 24'hF5E0FF, 24'h000000};
   logic        de [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        dv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_bcd   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bin", 32'(out_bin), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors including boundaries and an invalid digit.
      for (int i = 0; i < 6; i++) send(dw[i], db[i], de[i], dv[i], 1);
      drain();

      // Backpressure: result must hold and extra inputs must be ignored.
      rdy_force = 0;
      #10;
      send(32'h12345678, 24'hBC614E, 1'b0, 1'b0, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("bp_in_ready_conv", 32'(in_ready), 32'd0);
      in_bcd   = 32'h99999999;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      begin
         int n = 0;
         @(negedge clk);
         while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      for (int k = 0; k < 10; k++) begin
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_bin", 32'(out_bin), 32'hBC614E);
         chk("bp_in_ready_done", 32'(in_ready), 32'd0);
         if (k == 3) begin
            in_bcd   = 32'h00000001;
            in_valid = 1'b1;
         end
         if (k == 5) in_valid = 1'b0;
         @(negedge clk);
      end
      rdy_force = 1;
      drain();

      // Reset during iteration 15 aborts the conversion.
      send(32'h00054321, 24'h0, 1'b0, 1'b0, 0);
      repeat (14) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_bin", 32'(out_bin), 32'd0);
      chk("abort_out_err", 32'(out_err), 32'd0);
      chk("abort_out_ovf", 32'(out_ovf), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h00000255, 24'h0000FF, 1'b0, 1'b0, 1);
      drain();

      // Random valid words with random backpressure, decimal reference model.
      rand_rdy = 1;
      for (int t = 0; t < 300; t++) begin
         logic [31:0] w;
         longint      val;
         longint      p;
         w   = '0;
         val = 0;
         p   = 1;
         for (int d = 0; d < 8; d++) begin
            int dig;
            dig = $urandom_range(0, 9);
            w[d*4 +: 4] = 4'(dig);
            val += longint'(dig) * p;
            p   *= 10;
         end
         send(w, val[23:0], 1'b0, (val >= 64'd16777216), 1);
      end
      drain();
      rand_rdy = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_bcd_to_bin_seq
